multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle control sequencer for the 32-bit lab processor.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Drives the 2-bit select lines of the next-PC and writeback 3-to-1 muxes (select 00=in1, 01=in2, 10=in3), plus memory, IR, PC and register-file enables.
- Sits directly upstream of those muxes; consumes the decoder's instruction class, the ALU branch flag and the memory ready handshake.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles a memory request waits for mem_ready before a fault halt. Must be >= 1.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start/continue execution; sampled in IDLE and at each retire.
- instr_class  in  3  from decoder: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 JAL, 6 HALT, 7 illegal.
- branch_taken  in  1  ALU compare flag, valid in EXECUTE.
- mem_ready  in  1  memory completes current request this cycle.
- mem_re  out  1  read request (instruction fetch or load).
- mem_we  out  1  store request.
- ir_we  out  1  capture instruction register.
- pc_we  out  1  write PC.
- pc_sel  out  2  next-PC mux select: 00 PC+4, 01 branch target, 10 jump target.
- wb_sel  out  2  writeback mux select: 00 ALU result, 01 memory data, 10 link (PC+4).
- rf_we  out  1  register-file write.
- alu_en  out  1  ALU operand/result latch enable.
- halted  out  1  registered; HALT state reached.
- err  out  1  registered; illegal class or memory timeout.
- retired_count  out  CNT_W  registered count of retired instructions; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; class latch, wait counter, retired_count, halted and err all go to 0.
  - All combinational outputs are 0 in IDLE.
- Outputs:
  - All control outputs are combinational from the state register, class latch, mem_ready and branch_taken only.
  - Any output not named for a state is 0 in that state.
- IDLE: leave to FETCH when run=1.
- FETCH:
  - mem_re=1.
  - On mem_ready=1: ir_we=1, pc_we=1, pc_sel=00; next state DECODE.
- DECODE:
  - Latch instr_class into cls_q.
  - Class 6: next state HALT.
  - Class 7: next state HALT and set err.
  - Otherwise: next state EXECUTE.
- EXECUTE: alu_en=1, then by class:
  - BRANCH: pc_sel=01, pc_we=branch_taken; retire.
  - JUMP: pc_sel=10, pc_we=1; retire.
  - JAL: pc_sel=10, pc_we=1; next state WB.
  - ALU: next state WB.
  - LOAD/STORE: next state MEM.
- MEM:
  - LOAD holds mem_re=1; STORE holds mem_we=1; both held until mem_ready.
  - On mem_ready: LOAD goes to WB; STORE retires.
- WB: rf_we=1; wb_sel is 00 for ALU, 01 for LOAD, 10 for JAL; retire.
- Retire:
  - retired_count+1 on the retiring edge.
  - Next state FETCH if run=1, else IDLE.
  - run is ignored mid-instruction.
- HALT:
  - halted=1.
  - Absorbing state: all outputs 0 except halted and err; exit only via reset.
- Wait counter (FETCH and MEM):
  - Cleared on entry to FETCH/MEM; increments each cycle with mem_ready=0.
  - If the MEM_TIMEOUT-th cycle of a request has mem_ready=0: next state HALT, err=1.
  - mem_ready in the same cycle as the timeout: ready wins.
- Latency with mem_ready tied high:
  - BRANCH/JUMP 3 cycles; ALU/JAL/STORE 4; LOAD 5.
- retired_count wrap: all-ones +1 goes to 0, with no flag.
- Reset asserted mid-instruction: immediately IDLE; partial memory requests are abandoned.

Decomposition:
- Package ctrl_pkg holds:
  - state encoding: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT;
  - instruction class constants;
  - pc_sel and wb_sel code constants.
- One sub-module, mem_wait_timer:
  - parameter MEM_TIMEOUT;
  - inputs clr, waiting; output expired.

Test Plan:
- ALU instruction, mem_ready=1, run=1 after reset:
  - FETCH/DECODE/EXECUTE/WB over 4 cycles;
  - rf_we=1, wb_sel=00 in cycle 4;
  - retired_count 0 -> 1.
- LOAD with mem_ready low 3 cycles in MEM, MEM_TIMEOUT=16:
  - mem_re held 4 cycles;
  - WB with wb_sel=01;
  - total 8 cycles; err=0.
- BRANCH with branch_taken=0 then 1:
  - pc_sel=01 both times; pc_we=0 then 1;
  - no rf_we; 3 cycles each.
- JAL:
  - EXECUTE pc_sel=10, pc_we=1;
  - WB wb_sel=10, rf_we=1.
- MEM_TIMEOUT=4, mem_ready never asserted in FETCH:
  - mem_re for exactly 4 cycles, then halted=1, err=1;
  - further mem_ready ignored until rst_n pulse returns to IDLE with counters 0.
- instr_class=7:
  - HALT after DECODE, err=1, retired_count unchanged.
- Separately, run dropped mid-instruction:
  - completes and retires, then IDLE.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle control sequencer.
//   - state_t   : sequencer state encoding
//   - CLS_*     : instruction class codes from the decoder
//   - PC_SEL_*  : next-PC mux select codes (00 PC+4, 01 branch, 10 jump)
//   - WB_SEL_*  : writeback mux select codes (00 ALU, 01 memory, 10 link)
//   - ctrl_t    : bundle of the combinational control outputs
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    localparam logic [2:0] CLS_ALU     = 3'd0;
    localparam logic [2:0] CLS_LOAD    = 3'd1;
    localparam logic [2:0] CLS_STORE   = 3'd2;
    localparam logic [2:0] CLS_BRANCH  = 3'd3;
    localparam logic [2:0] CLS_JUMP    = 3'd4;
    localparam logic [2:0] CLS_JAL     = 3'd5;
    localparam logic [2:0] CLS_HALT    = 3'd6;
    localparam logic [2:0] CLS_ILLEGAL = 3'd7;

    localparam logic [1:0] PC_SEL_PC4  = 2'b00;
    localparam logic [1:0] PC_SEL_BR   = 2'b01;
    localparam logic [1:0] PC_SEL_JMP  = 2'b10;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

    typedef struct packed {
        logic       mem_re;
        logic       mem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic [1:0] wb_sel;
        logic       rf_we;
        logic       alu_en;
    } ctrl_t;

    // Writeback source for a class that reaches WB: loads return memory
    // data, JAL writes the link address, everything else the ALU result.
    function automatic logic [1:0] wb_sel_for(input logic [2:0] cls);
        case (cls)
            CLS_LOAD: wb_sel_for = WB_SEL_MEM;
            CLS_JAL:  wb_sel_for = WB_SEL_LINK;
            default:  wb_sel_for = WB_SEL_ALU;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles a memory request has been outstanding
// without mem_ready and flags the cycle that would exhaust the budget.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return the count to zero (no request pending / request done)
//   waiting    : a request is pending and memory did not answer this cycle
//   expired    : this is the MEM_TIMEOUT-th cycle of the request and it is
//                still unanswered (combinational)
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic waiting,
    output logic expired
);

    // The count never exceeds MEM_TIMEOUT-1: the request is abandoned on
    // the cycle the count reaches that value.
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of unanswered cycles before the current one, so
    // the k-th cycle of a request sees cnt == k-1.
    assign expired = waiting && (cnt == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (waiting && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control sequencer for the 32-bit multicycle lab CPU.
// Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives
// the datapath enables and the next-PC / writeback mux selects.
//   clk, rst_n     : clock, asynchronous active-low reset
//   run            : start/continue; sampled in IDLE and at retire
//   instr_class    : decoder class (sampled in DECODE)
//   branch_taken   : ALU compare result, used in EXECUTE for branches
//   mem_ready      : memory completes the current request this cycle
//   mem_re/mem_we  : memory read (fetch/load) / write (store) request
//   ir_we, pc_we   : instruction register / PC write enables
//   pc_sel, wb_sel : next-PC and writeback mux selects
//   rf_we, alu_en  : register-file write, ALU latch enable
//   halted, err    : registered status, held until reset
//   retired_count  : registered retired-instruction count (wraps)
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [2:0]       instr_class,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_re,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [1:0]       wb_sel,
    output logic             rf_we,
    output logic             alu_en,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired_count
);

    state_t     state, state_n;
    logic [2:0] cls_q;
    ctrl_t      ctl;
    logic       retire;
    logic       set_err;

    logic       mem_state;
    logic       tmr_wait;
    logic       tmr_clr;
    logic       tmr_expired;

    // FETCH and MEM are the only states with a memory request in flight.
    // Any cycle outside them, or an answered cycle, restarts the budget.
    assign mem_state = (state == ST_FETCH) || (state == ST_MEM);
    assign tmr_wait  = mem_state && !mem_ready;
    assign tmr_clr   = !mem_state || mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .waiting(tmr_wait),
        .expired(tmr_expired)
    );

    // Control outputs and next state. Outputs depend only on state, cls_q,
    // mem_ready and branch_taken; instr_class only steers DECODE's exit.
    always_comb begin
        ctl     = '0;
        state_n = state;
        retire  = 1'b0;
        set_err = 1'b0;

        case (state)
            ST_IDLE: begin
                if (run) state_n = ST_FETCH;
            end

            ST_FETCH: begin
                ctl.mem_re = 1'b1;
                if (mem_ready) begin
                    ctl.ir_we  = 1'b1;
                    ctl.pc_we  = 1'b1;
                    ctl.pc_sel = PC_SEL_PC4;
                    state_n    = ST_DECODE;
                end else if (tmr_expired) begin
                    state_n = ST_HALT;
                    set_err = 1'b1;
                end
            end

            ST_DECODE: begin
                case (instr_class)
                    CLS_HALT:    state_n = ST_HALT;
                    CLS_ILLEGAL: begin
                        state_n = ST_HALT;
                        set_err = 1'b1;
                    end
                    default:     state_n = ST_EXECUTE;
                endcase
            end

            ST_EXECUTE: begin
                ctl.alu_en = 1'b1;
                case (cls_q)
                    CLS_BRANCH: begin
                        ctl.pc_sel = PC_SEL_BR;
                        ctl.pc_we  = branch_taken;
                        retire     = 1'b1;
                    end
                    CLS_JUMP: begin
                        ctl.pc_sel = PC_SEL_JMP;
                        ctl.pc_we  = 1'b1;
                        retire     = 1'b1;
                    end
                    CLS_JAL: begin
                        ctl.pc_sel = PC_SEL_JMP;
                        ctl.pc_we  = 1'b1;
                        state_n    = ST_WB;
                    end
                    CLS_ALU:   state_n = ST_WB;
                    CLS_LOAD,
                    CLS_STORE: state_n = ST_MEM;
                    default: begin
                        // HALT/illegal never get past DECODE; treat a
                        // corrupted latch as a fault rather than guess.
                        state_n = ST_HALT;
                        set_err = 1'b1;
                    end
                endcase
            end

            ST_MEM: begin
                if (cls_q == CLS_LOAD) ctl.mem_re = 1'b1;
                else                   ctl.mem_we = 1'b1;
                if (mem_ready) begin
                    if (cls_q == CLS_LOAD) state_n = ST_WB;
                    else                   retire  = 1'b1;
                end else if (tmr_expired) begin
                    state_n = ST_HALT;
                    set_err = 1'b1;
                end
            end

            ST_WB: begin
                ctl.rf_we  = 1'b1;
                ctl.wb_sel = wb_sel_for(cls_q);
                retire     = 1'b1;
            end

            ST_HALT: begin
                state_n = ST_HALT;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // run is only looked at between instructions.
        if (retire) state_n = run ? ST_FETCH : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cls_q         <= '0;
            retired_count <= '0;
            halted        <= 1'b0;
            err           <= 1'b0;
        end else begin
            state  <= state_n;
            halted <= (state_n == ST_HALT);
            if (state == ST_DECODE) cls_q <= instr_class;
            if (retire)             retired_count <= retired_count + 1'b1;
            if (set_err)            err <= 1'b1;
        end
    end

    assign mem_re = ctl.mem_re;
    assign mem_we = ctl.mem_we;
    assign ir_we  = ctl.ir_we;
    assign pc_we  = ctl.pc_we;
    assign pc_sel = ctl.pc_sel;
    assign wb_sel = ctl.wb_sel;
    assign rf_we  = ctl.rf_we;
    assign alu_en = ctl.alu_en;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. Each instruction is scripted phase by phase
// from the sequencing rules; every cycle's expected outputs are compared
// at the falling edge, and a few literal latencies/counts pin the script.
module tb_multicycle_ctrl;

    localparam int TO = 4;   // memory timeout used by this bench
    localparam int CW = 4;   // small counter so wrap is reachable

    localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BRANCH = 3;
    localparam int C_JUMP = 4, C_JAL = 5, C_HALT = 6, C_ILL = 7;

    logic          clk, rst_n, run, branch_taken, mem_ready;
    logic [2:0]    instr_class;
    logic          mem_re, mem_we, ir_we, pc_we, rf_we, alu_en, halted, err;
    logic [1:0]    pc_sel, wb_sel;
    logic [CW-1:0] retired_count;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .instr_class  (instr_class),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .wb_sel       (wb_sel),
        .rf_we        (rf_we),
        .alu_en       (alu_en),
        .halted       (halted),
        .err          (err),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          mem_re, mem_we, ir_we, pc_we;
        logic [1:0]    pc_sel, wb_sel;
        logic          rf_we, alu_en, halted, err;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t  exp_o, act_o;
    logic  chk_en = 1'b0;
    string tag = "init";
    int    cyc = 0;

    // model state: what the registered status must read
    int    m_cnt = 0;
    logic  m_halted = 1'b0, m_err = 1'b0;

    // literal expectations handed to the compare process
    string lit_name [64];
    int    lit_act  [64];
    int    lit_exp  [64];
    int    lit_wr = 0;
    int    lit_rd = 0;

    int    checks = 0, failures = 0;

    assign act_o = {mem_re, mem_we, ir_we, pc_we, pc_sel, wb_sel,
                    rf_we, alu_en, halted, err, retired_count};

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (act_o !== exp_o) begin
                failures++;
                $display("FAIL %s cycle %0d: got re%b we%b ir%b pcw%b ps%b ws%b rf%b alu%b halt%b err%b cnt%0d, expected re%b we%b ir%b pcw%b ps%b ws%b rf%b alu%b halt%b err%b cnt%0d",
                         tag, cyc, act_o.mem_re, act_o.mem_we, act_o.ir_we, act_o.pc_we,
                         act_o.pc_sel, act_o.wb_sel, act_o.rf_we, act_o.alu_en,
                         act_o.halted, act_o.err, act_o.cnt,
                         exp_o.mem_re, exp_o.mem_we, exp_o.ir_we, exp_o.pc_we,
                         exp_o.pc_sel, exp_o.wb_sel, exp_o.rf_we, exp_o.alu_en,
                         exp_o.halted, exp_o.err, exp_o.cnt);
            end
        end
        while (lit_rd != lit_wr) begin
            checks++;
            if (lit_act[lit_rd % 64] != lit_exp[lit_rd % 64]) begin
                failures++;
                $display("FAIL %s: got %0d, expected %0d", lit_name[lit_rd % 64],
                         lit_act[lit_rd % 64], lit_exp[lit_rd % 64]);
            end
            lit_rd++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk_lit(input string name, input int act, input int expv);
        lit_name[lit_wr % 64] = name;
        lit_act[lit_wr % 64]  = act;
        lit_exp[lit_wr % 64]  = expv;
        lit_wr++;
    endtask

    // One clock: publish this cycle's expected outputs (inputs are already
    // applied), let the falling edge compare, then advance past the edge.
    task automatic step(input logic re, we, irw, pcw, input logic [1:0] ps, ws,
                        input logic rfw, alu);
        exp_o = {re, we, irw, pcw, ps, ws, rfw, alu, m_halted, m_err, CW'(m_cnt)};
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic quiet();
        step(0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_cnt = 0; m_halted = 1'b0; m_err = 1'b0;
        tag = "reset";
        quiet();
        rst_n = 1'b1;
    endtask

    task automatic halt_now(input logic e);
        m_halted = 1'b1;
        if (e) m_err = 1'b1;
    endtask

    // Run one instruction from FETCH. fst/mst: unanswered cycles before
    // mem_ready in FETCH/MEM; TO or more means the request times out.
    task automatic do_instr(input int cls, input int fst, input int mst,
                            input logic bt, input logic run_after, input string name);
        tag = name;
        instr_class  = 3'(cls);
        branch_taken = bt;
        mem_ready    = 1'b0;
        for (int i = 0; i < fst; i++) begin
            step(1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
            if (i == TO - 1) begin halt_now(1'b1); return; end
        end
        mem_ready = 1'b1;
        step(1, 0, 1, 1, 2'b00, 2'b00, 0, 0);
        run = run_after;
        quiet();                                          // DECODE
        if (cls == C_HALT) begin halt_now(1'b0); return; end
        if (cls == C_ILL)  begin halt_now(1'b1); return; end
        case (cls)
            C_BRANCH: step(0, 0, 0, bt, 2'b01, 2'b00, 0, 1);
            C_JUMP, C_JAL: step(0, 0, 0, 1, 2'b10, 2'b00, 0, 1);
            default:  step(0, 0, 0, 0, 2'b00, 2'b00, 0, 1);
        endcase
        if (cls == C_LOAD || cls == C_STORE) begin
            mem_ready = 1'b0;
            for (int i = 0; i < mst; i++) begin
                step(cls == C_LOAD, cls == C_STORE, 0, 0, 2'b00, 2'b00, 0, 0);
                if (i == TO - 1) begin halt_now(1'b1); return; end
            end
            mem_ready = 1'b1;
            step(cls == C_LOAD, cls == C_STORE, 0, 0, 2'b00, 2'b00, 0, 0);
        end
        if (cls == C_ALU)  step(0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        if (cls == C_LOAD) step(0, 0, 0, 0, 2'b00, 2'b01, 1, 0);
        if (cls == C_JAL)  step(0, 0, 0, 0, 2'b00, 2'b10, 1, 0);
        m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    int c0;

    initial begin
        rst_n = 1'b0; run = 1'b0; instr_class = '0;
        branch_taken = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        tag = "reset";
        quiet();
        quiet();
        rst_n = 1'b1;
        run = 1'b1;
        tag = "idle";
        quiet();

        c0 = cyc; do_instr(C_ALU, 0, 0, 0, 1, "alu");
        chk_lit("alu_latency", cyc - c0, 4);
        chk_lit("alu_count", int'(retired_count), 1);

        c0 = cyc; do_instr(C_LOAD, 0, 3, 0, 1, "load_stall");
        chk_lit("load_stall_latency", cyc - c0, 8);
        chk_lit("load_stall_err", int'(err), 0);

        c0 = cyc; do_instr(C_BRANCH, 0, 0, 0, 1, "branch_nt");
        chk_lit("branch_nt_latency", cyc - c0, 3);
        c0 = cyc; do_instr(C_BRANCH, 0, 0, 1, 1, "branch_t");
        chk_lit("branch_t_latency", cyc - c0, 3);

        c0 = cyc; do_instr(C_JAL, 0, 0, 0, 1, "jal");
        chk_lit("jal_latency", cyc - c0, 4);
        c0 = cyc; do_instr(C_JUMP, 0, 0, 0, 1, "jump");
        chk_lit("jump_latency", cyc - c0, 3);
        do_instr(C_STORE, 2, 1, 0, 1, "store_stall");
        c0 = cyc; do_instr(C_LOAD, 0, 0, 0, 1, "load");
        chk_lit("load_latency", cyc - c0, 5);
        c0 = cyc; do_instr(C_STORE, 0, 0, 0, 1, "store");
        chk_lit("store_latency", cyc - c0, 4);

        // fetch answered on the last allowed cycle: ready wins
        c0 = cyc; do_instr(C_ALU, 3, 0, 0, 1, "fetch_edge");
        chk_lit("fetch_edge_latency", cyc - c0, 7);
        chk_lit("fetch_edge_err", int'(err), 0);

        // run dropped mid-instruction: still retires, then parks in IDLE
        do_instr(C_ALU, 0, 0, 0, 0, "run_drop");
        tag = "idle_parked";
        quiet();
        quiet();
        chk_lit("run_drop_count", int'(retired_count), 11);
        run = 1'b1;
        quiet();

        // 11 + 5 retires wraps the 4-bit counter to 0
        for (int k = 0; k < 5; k++) do_instr(C_JUMP, 0, 0, 0, 1, "wrap");
        chk_lit("wrap_count", int'(retired_count), 0);
        do_instr(C_JUMP, 0, 0, 0, 1, "post_wrap");

        do_instr(C_ILL, 0, 0, 0, 1, "illegal");
        tag = "illegal_halt";
        for (int k = 0; k < 3; k++) quiet();
        chk_lit("illegal_count", int'(retired_count), 1);
        chk_lit("illegal_err", int'(err), 1);

        do_reset();
        run = 1'b1; tag = "idle"; quiet();
        do_instr(C_HALT, 0, 0, 0, 1, "halt");
        tag = "halt_hold";
        quiet();
        quiet();
        chk_lit("halt_err", int'(err), 0);
        chk_lit("halt_halted", int'(halted), 1);

        do_reset();
        run = 1'b1; tag = "idle"; quiet();
        c0 = cyc; do_instr(C_ALU, 10, 0, 0, 1, "fetch_timeout");
        chk_lit("fetch_timeout_cycles", cyc - c0, 4);
        mem_ready = 1'b1;
        tag = "timeout_hold";
        for (int k = 0; k < 3; k++) quiet();
        chk_lit("fetch_timeout_err", int'(err), 1);

        do_reset();
        chk_lit("reset_count", int'(retired_count), 0);
        run = 1'b1; tag = "idle"; quiet();
        c0 = cyc; do_instr(C_STORE, 0, 10, 0, 1, "mem_timeout");
        chk_lit("mem_timeout_cycles", cyc - c0, 7);
        tag = "timeout_hold";
        quiet();

        // reset asserted while a fetch is pending abandons it
        do_reset();
        run = 1'b1; tag = "idle"; quiet();
        mem_ready = 1'b0; tag = "fetch_abort";
        step(1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        step(1, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        run = 1'b0;
        do_reset();
        tag = "idle_after_abort";
        quiet();
        run = 1'b1;
        quiet();
        do_instr(C_LOAD, 0, 0, 0, 0, "recover");
        tag = "final_idle";
        quiet();
        chk_lit("recover_count", int'(retired_count), 1);
        quiet();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
